// File: rtl/ifid_pkg.sv
// Shared types and constants for the IF/ID skid-buffered stage register.
// Contents: control state encoding, default widths, the payload layout
// (PC, incremented PC, writeback flag) and the saturation limit of the flush
// counter.
package ifid_pkg;

  localparam int unsigned IFID_PC_W  = 8;
  localparam int unsigned IFID_CNT_W = 8;

  // Payload bits carried per instruction: pc + incre_pc + wb_ff.
  localparam int unsigned IFID_PAYLOAD_W = 2 * IFID_PC_W + 1;

  // Saturation limit of the flushed-instruction counter at the default width.
  localparam logic [IFID_CNT_W-1:0] IFID_CNT_MAX = '1;

  // Control states, encoded as (main_valid, skid_valid).
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } state_e;

  // Payload layout at the default PC width. Field order matches the flat
  // vector {pc, incre_pc, wb_ff} used inside the stage.
  typedef struct packed {
    logic [IFID_PC_W-1:0] pc;
    logic [IFID_PC_W-1:0] incre_pc;
    logic                 wb_ff;
  } payload_t;

  // Payload width for an arbitrary PC width.
  function automatic int unsigned payload_w(input int unsigned pc_w);
    return 2 * pc_w + 1;
  endfunction

endpackage

// File: rtl/ifid_skid_stage_if.sv
// Fetch-side and decode-side handshake bundle of the IF/ID stage.
// Fetch side: in_valid, PC_in, incre_pc_in, wb_ff_in -> stage; in_ready <- stage.
// Decode side: out_valid, PC_out, incre_pc_out, wb_ff_out <- stage; out_ready -> stage.
// The stage connects to the slave modport; the environment uses master.
interface ifid_skid_stage_if #(
  parameter int unsigned PC_W = 8
);

  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] PC_in;
  logic [PC_W-1:0] incre_pc_in;
  logic            wb_ff_in;

  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] PC_out;
  logic [PC_W-1:0] incre_pc_out;
  logic            wb_ff_out;

  modport slave (
    input  in_valid, PC_in, incre_pc_in, wb_ff_in, out_ready,
    output in_ready, out_valid, PC_out, incre_pc_out, wb_ff_out
  );

  modport master (
    output in_valid, PC_in, incre_pc_in, wb_ff_in, out_ready,
    input  in_ready, out_valid, PC_out, incre_pc_out, wb_ff_out
  );

endinterface

// File: rtl/ifid_payload_reg.sv
// Load-enabled payload register with synchronous clear (clear wins over load).
// Ports: clk_i clock, clr_i sync clear, ld_i load enable, d_i data in,
// q_o registered data out.
module ifid_payload_reg #(
  parameter int unsigned W = 17
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/ifid_skid_stage.sv
// IF/ID pipeline stage register with a two-entry skid buffer, synchronous
// flush and a saturating count of flushed instructions.
// Ports: CLK clock; RST sync active-high reset; FLUSH sync flush;
// bus handshake/payload bundle (slave side); flush_cnt saturating count of
// valid entries discarded by FLUSH.
// in_ready is a register (NOT skid_valid), so decode stall never reaches
// fetch combinationally.
module ifid_skid_stage
  import ifid_pkg::*;
#(
  parameter int unsigned PC_W  = IFID_PC_W,
  parameter int unsigned CNT_W = IFID_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  ifid_skid_stage_if.slave bus,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned PAY_W = payload_w(PC_W);
  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  state_e           state_q;
  logic             out_valid_q;
  logic             in_ready_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;

  logic             in_xfer;
  logic             main_ld;
  logic             skid_ld;
  logic             pay_clr;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] main_d;
  logic [PAY_W-1:0] main_q;
  logic [PAY_W-1:0] skid_q;
  logic [1:0]       flush_inc;
  logic [CNT_W+1:0] cnt_sum;

  assign in_pay  = {bus.PC_in, bus.incre_pc_in, bus.wb_ff_in};
  assign in_xfer = bus.in_valid & in_ready_q;
  assign pay_clr = RST | FLUSH;

  // Datapath steering: which payload register loads, and from where.
  always_comb begin
    main_ld = 1'b0;
    skid_ld = 1'b0;
    main_d  = in_pay;
    unique case (state_q)
      ST_EMPTY: main_ld = bus.in_valid;
      ST_FULL: begin
        main_ld = bus.in_valid & bus.out_ready;
        skid_ld = bus.in_valid & ~bus.out_ready;
      end
      ST_SKID: begin
        main_ld = bus.out_ready;
        main_d  = skid_q;
      end
      default: ;
    endcase
  end

  // Entries lost to a flush: an unconsumed main entry, the skid entry and
  // any input that would have been accepted this cycle.
  always_comb begin
    flush_inc   = 2'(out_valid_q & ~bus.out_ready)
                + 2'(state_q == ST_SKID)
                + 2'(in_xfer);
    cnt_sum     = (CNT_W + 2)'(flush_cnt_q) + (CNT_W + 2)'(flush_inc);
    flush_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : cnt_sum[CNT_W-1:0];
  end

  // Control FSM with registered handshake flags; reset over flush over handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= '0;
    end else if (FLUSH) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      flush_cnt_q <= flush_cnt_d;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (bus.in_valid) begin
            state_q     <= ST_FULL;
            out_valid_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (bus.in_valid && !bus.out_ready) begin
            state_q    <= ST_SKID;
            in_ready_q <= 1'b0;
          end else if (!bus.in_valid && bus.out_ready) begin
            // Payload is left as-is; decode qualifies with out_valid.
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_SKID: begin
          if (bus.out_ready) begin
            state_q    <= ST_FULL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  ifid_payload_reg #(.W(PAY_W)) u_main_reg (
    .clk_i (CLK),
    .clr_i (pay_clr),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  ifid_payload_reg #(.W(PAY_W)) u_skid_reg (
    .clk_i (CLK),
    .clr_i (pay_clr),
    .ld_i  (skid_ld),
    .d_i   (in_pay),
    .q_o   (skid_q)
  );

  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign {bus.PC_out, bus.incre_pc_out, bus.wb_ff_out} = main_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_ifid_skid_stage.sv
// Self-checking bench for ifid_skid_stage: a directed vector table on an
// 8-bit-counter instance, plus a hand sequence for counter saturation on a
// 2-bit-counter instance.
module tb_ifid_skid_stage;
  import ifid_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       FLUSH;
  logic       RST2;
  logic       FLUSH2;
  logic [7:0] flush_cnt;
  logic [1:0] flush_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ifid_skid_stage_if #(.PC_W(8)) bus ();
  ifid_skid_stage_if #(.PC_W(8)) bus2 ();

  ifid_skid_stage #(.PC_W(8), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .bus       (bus),
    .flush_cnt (flush_cnt)
  );

  ifid_skid_stage #(.PC_W(8), .CNT_W(2)) dut_sat (
    .CLK       (CLK),
    .RST       (RST2),
    .FLUSH     (FLUSH2),
    .bus       (bus2),
    .flush_cnt (flush_cnt2)
  );

  typedef struct {
    logic       rst;
    logic       flush;
    logic       iv;
    payload_t   din;
    logic       ordy;
    logic       e_ov;
    logic       e_ir;
    payload_t   e_pay;
    logic [7:0] e_cnt;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rst, input logic flush, input logic iv,
    input logic [7:0] pc, input logic [7:0] inc, input logic wb, input logic ordy,
    input logic eov, input logic eir,
    input logic [7:0] epc, input logic [7:0] einc, input logic ewb, input logic [7:0] ecnt);
    vec_t v;
    v.rst   = rst;
    v.flush = flush;
    v.iv    = iv;
    v.din   = '{pc: pc, incre_pc: inc, wb_ff: wb};
    v.ordy  = ordy;
    v.e_ov  = eov;
    v.e_ir  = eir;
    v.e_pay = '{pc: epc, incre_pc: einc, wb_ff: ewb};
    v.e_cnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //            rst fl iv pc     inc    wb or   ov ir pc     inc    wb cnt
    vecs[0]  = mk(1, 0, 1, 8'hAA, 8'hBB, 1, 1,   0, 1, 8'h00, 8'h00, 0, 8'd0);
    vecs[1]  = mk(1, 0, 1, 8'h55, 8'h66, 0, 0,   0, 1, 8'h00, 8'h00, 0, 8'd0);
    vecs[2]  = mk(0, 0, 1, 8'h10, 8'h11, 1, 1,   1, 1, 8'h10, 8'h11, 1, 8'd0);
    vecs[3]  = mk(0, 0, 1, 8'h11, 8'h12, 0, 1,   1, 1, 8'h11, 8'h12, 0, 8'd0);
    vecs[4]  = mk(0, 0, 1, 8'h12, 8'h13, 1, 1,   1, 1, 8'h12, 8'h13, 1, 8'd0);
    vecs[5]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 1,   0, 1, 8'h12, 8'h13, 1, 8'd0);
    vecs[6]  = mk(0, 0, 1, 8'h20, 8'h21, 0, 0,   1, 1, 8'h20, 8'h21, 0, 8'd0);
    vecs[7]  = mk(0, 0, 1, 8'h21, 8'h22, 1, 0,   1, 0, 8'h20, 8'h21, 0, 8'd0);
    vecs[8]  = mk(0, 0, 1, 8'h99, 8'h9A, 1, 0,   1, 0, 8'h20, 8'h21, 0, 8'd0);
    vecs[9]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 1,   1, 1, 8'h21, 8'h22, 1, 8'd0);
    vecs[10] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1,   0, 1, 8'h21, 8'h22, 1, 8'd0);
    vecs[11] = mk(0, 0, 1, 8'h30, 8'h31, 1, 0,   1, 1, 8'h30, 8'h31, 1, 8'd0);
    vecs[12] = mk(0, 0, 1, 8'h31, 8'h32, 0, 0,   1, 0, 8'h30, 8'h31, 1, 8'd0);
    vecs[13] = mk(0, 1, 0, 8'h00, 8'h00, 0, 0,   0, 1, 8'h00, 8'h00, 0, 8'd2);
    vecs[14] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1,   0, 1, 8'h00, 8'h00, 0, 8'd2);
    vecs[15] = mk(0, 0, 1, 8'h40, 8'h41, 1, 0,   1, 1, 8'h40, 8'h41, 1, 8'd2);
    vecs[16] = mk(0, 1, 1, 8'h41, 8'h42, 1, 1,   0, 1, 8'h00, 8'h00, 0, 8'd3);
    vecs[17] = mk(0, 0, 0, 8'h00, 8'h00, 0, 1,   0, 1, 8'h00, 8'h00, 0, 8'd3);
    vecs[18] = mk(0, 0, 1, 8'h50, 8'h51, 0, 0,   1, 1, 8'h50, 8'h51, 0, 8'd3);
    vecs[19] = mk(0, 1, 1, 8'h52, 8'h53, 1, 0,   0, 1, 8'h00, 8'h00, 0, 8'd5);
    vecs[20] = mk(0, 1, 0, 8'h00, 8'h00, 0, 0,   0, 1, 8'h00, 8'h00, 0, 8'd5);
    vecs[21] = mk(0, 0, 1, 8'h60, 8'h61, 1, 0,   1, 1, 8'h60, 8'h61, 1, 8'd5);
    vecs[22] = mk(1, 1, 1, 8'h62, 8'h63, 1, 0,   0, 1, 8'h00, 8'h00, 0, 8'd0);
    vecs[23] = mk(0, 0, 1, 8'h70, 8'h71, 0, 0,   1, 1, 8'h70, 8'h71, 0, 8'd0);
    vecs[24] = mk(0, 0, 1, 8'h71, 8'h72, 1, 0,   1, 0, 8'h70, 8'h71, 0, 8'd0);
    vecs[25] = mk(1, 0, 0, 8'h00, 8'h00, 0, 0,   0, 1, 8'h00, 8'h00, 0, 8'd0);

    // Random payload while reset is asserted.
    for (int r = 0; r < 2; r++) begin
      vecs[r].din.pc       = 8'($urandom);
      vecs[r].din.incre_pc = 8'($urandom);
    end

    // Saturation instance stays in reset while the table runs.
    RST2             = 1'b1;
    FLUSH2           = 1'b0;
    bus2.in_valid    = 1'b0;
    bus2.PC_in       = '0;
    bus2.incre_pc_in = '0;
    bus2.wb_ff_in    = 1'b0;
    bus2.out_ready   = 1'b0;

    for (int i = 0; i < NV; i++) begin
      RST             = vecs[i].rst;
      FLUSH           = vecs[i].flush;
      bus.in_valid    = vecs[i].iv;
      bus.PC_in       = vecs[i].din.pc;
      bus.incre_pc_in = vecs[i].din.incre_pc;
      bus.wb_ff_in    = vecs[i].din.wb_ff;
      bus.out_ready   = vecs[i].ordy;
      tick();
      chk("out_valid",    i, 32'(bus.out_valid),    32'(vecs[i].e_ov));
      chk("in_ready",     i, 32'(bus.in_ready),     32'(vecs[i].e_ir));
      chk("PC_out",       i, 32'(bus.PC_out),       32'(vecs[i].e_pay.pc));
      chk("incre_pc_out", i, 32'(bus.incre_pc_out), 32'(vecs[i].e_pay.incre_pc));
      chk("wb_ff_out",    i, 32'(bus.wb_ff_out),    32'(vecs[i].e_pay.wb_ff));
      chk("flush_cnt",    i, 32'(flush_cnt),        32'(vecs[i].e_cnt));
    end

    // Saturating counter: five flushes of one held entry on a 2-bit counter.
    RST   = 1'b0;
    FLUSH = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk("sat_reset_cnt", 100, 32'(flush_cnt2), 32'd0);
    RST2 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus2.in_valid    = 1'b1;
      bus2.PC_in       = 8'(8'h80 + k);
      bus2.incre_pc_in = 8'(8'h81 + k);
      bus2.out_ready   = 1'b0;
      FLUSH2           = 1'b0;
      tick();
      chk("sat_load_valid", 110 + k, 32'(bus2.out_valid), 32'd1);
      chk("sat_load_pc",    110 + k, 32'(bus2.PC_out),    32'(8'h80 + k));
      bus2.in_valid = 1'b0;
      FLUSH2        = 1'b1;
      tick();
      FLUSH2 = 1'b0;
      chk("sat_flush_valid", 120 + k, 32'(bus2.out_valid), 32'd0);
      chk("sat_cnt",         120 + k, 32'(flush_cnt2), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
    end
    RST2 = 1'b1;
    tick();
    chk("sat_cnt_after_rst", 130, 32'(flush_cnt2), 32'd0);
    chk("sat_ready_after_rst", 130, 32'(bus2.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
